// File: rtl/mem_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mem_test_seq
//  Purpose  : Board-level SRAM self-test sequencer. Writes the pattern
//             word(i) = i ^ PAT_XOR over [base, base+length), reads it back
//             through the SRAM core stage and counts mismatches.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous reset, active low
//             start      - begin a test (accepted only when not busy)
//             base_addr  - first address, latched on start
//             length     - word count, latched on start (0 allowed)
//             control    - command to core stage: 00 idle, 01 write, 10 read
//             addr       - current address (base + idx, wraps)
//             data_out   - write data toward the shared bus
//             data_oe    - 1 = drive the shared bus with data_out
//             data_in    - bus value during reads
//             busy       - test in progress
//             done       - test finished, held until next accepted start
//             err_count  - mismatch count, saturating at 16'hFFFF
//             fail_addr  - address of the first mismatch (0 if none)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_test_seq #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                HOLD    = 2,        // legal range 2..15
    parameter logic [DATA_W-1:0] PAT_XOR = 16'h5A5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [1:0]        control,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int              c_TMR_W     = 4;
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(HOLD - 1);

    localparam logic [1:0] c_CTL_IDLE  = 2'b00;
    localparam logic [1:0] c_CTL_WRITE = 2'b01;
    localparam logic [1:0] c_CTL_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WGAP = 3'd2,
        S_RD   = 3'd3,
        S_RGAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TMR_W-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic [DATA_W-1:0]   r_sample;
    logic [15:0]         r_err;
    logic [ADDR_W-1:0]   r_fail;

    logic [ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]   w_word;
    logic                w_last_hold;
    logic                w_last_idx;
    logic                w_mismatch;
    logic                w_idle_like;

    assign w_cur_addr  = r_base + r_idx;              // wraps mod 2^ADDR_W
    assign w_word      = DATA_W'(r_idx) ^ PAT_XOR;
    assign w_last_hold = (r_timer == c_HOLD_LAST);
    assign w_last_idx  = (r_idx == (r_len - ADDR_W'(1)));
    assign w_mismatch  = (r_sample != w_word);
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

    assign busy      = !w_idle_like;
    assign done      = (r_state == S_DONE);
    assign err_count = r_err;
    assign fail_addr = r_fail;

    // ------------------------------------------------------------------
    // Next state and bus outputs. Outputs decode the registered state so
    // that an asynchronous reset forces them to idle values immediately.
    // Every access is followed by a gap state, so control can never step
    // directly between WRITE and READ.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        control     = c_CTL_IDLE;
        addr        = '0;
        data_out    = '0;
        data_oe     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? S_DONE : S_WR;
                end
            end
            S_WR: begin
                control  = c_CTL_WRITE;
                addr     = w_cur_addr;
                data_out = w_word;
                data_oe  = 1'b1;
                if (w_last_hold) begin
                    w_state_nxt = S_WGAP;
                end
            end
            S_WGAP: begin
                // Keep address and data driven one extra cycle as hold time.
                addr        = w_cur_addr;
                data_out    = w_word;
                data_oe     = 1'b1;
                w_state_nxt = w_last_idx ? S_RD : S_WR;
            end
            S_RD: begin
                control = c_CTL_READ;
                addr    = w_cur_addr;
                if (w_last_hold) begin
                    w_state_nxt = S_RGAP;
                end
            end
            S_RGAP: begin
                addr        = w_cur_addr;
                w_state_nxt = w_last_idx ? S_DONE : S_RD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_base   <= '0;
            r_len    <= '0;
            r_sample <= '0;
            r_err    <= '0;
            r_fail   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_len   <= length;
                        r_idx   <= '0;
                        r_timer <= '0;
                        r_err   <= '0;
                        r_fail  <= '0;
                    end
                end
                S_WR: begin
                    r_timer <= w_last_hold ? '0 : r_timer + c_TMR_W'(1);
                end
                S_WGAP: begin
                    r_idx <= w_last_idx ? '0 : r_idx + ADDR_W'(1);
                end
                S_RD: begin
                    r_timer <= w_last_hold ? '0 : r_timer + c_TMR_W'(1);
                    // The core stage returns data one cycle after the read
                    // strobe, so only the final hold cycle carries valid data.
                    if (w_last_hold) begin
                        r_sample <= data_in;
                    end
                end
                S_RGAP: begin
                    if (w_mismatch) begin
                        if (r_err != 16'hFFFF) begin
                            r_err <= r_err + 16'd1;
                        end
                        if (r_err == 16'd0) begin
                            r_fail <= w_cur_addr;
                        end
                    end
                    if (!w_last_idx) begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_test_seq
//  Purpose  : Directed self-checking bench for mem_test_seq with a simple
//             SRAM core-stage model (one cycle read latency, optional
//             injected faults at 0x0012/0x0013).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_test_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic [1:0]  control;
    logic [15:0] addr;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [15:0] fail_addr;

    always #5 clk = ~clk;

    mem_test_seq #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .HOLD    (2),
        .PAT_XOR (16'h5A5A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .control   (control),
        .addr      (addr),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- SRAM core-stage model ----------------
    // fault_mode 0: ideal; 1: bit0 stuck-at-0 at 0x12/0x13; 2: bit0 inverted there
    logic [15:0] mem [0:65535];
    int          fault_mode = 0;
    int          bad_bus    = 0;
    logic [1:0]  prev_ctrl  = 2'b00;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [15:0] a;
        logic [15:0] d;
    } acc_t;
    acc_t acc_log[$];

    function automatic logic [15:0] rd_fault(input logic [15:0] v, input logic [15:0] a);
        if (a == 16'h0012 || a == 16'h0013) begin
            if (fault_mode == 1) return v & 16'hFFFE;
            if (fault_mode == 2) return v ^ 16'h0001;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (control == 2'b01) mem[addr] <= data_out;
        data_in <= (control == 2'b10) ? rd_fault(mem[addr], addr) : 16'h0000;
        if (prev_ctrl == 2'b00 && control != 2'b00)
            acc_log.push_back('{ctrl: control, a: addr, d: data_out});
        if ((prev_ctrl == 2'b01 && control == 2'b10) || (prev_ctrl == 2'b10 && control == 2'b01))
            bad_bus++;
        if ((control == 2'b01 && !data_oe) || (control == 2'b10 && data_oe))
            bad_bus++;
        prev_ctrl <= control;
    end

    // Start a test and count busy cycles; optional stray start during busy.
    task automatic run_test(input logic [15:0] b, input logic [15:0] l, input bit pulse,
                            output int cyc);
        @(negedge clk);
        acc_log.delete();
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            if (pulse && cyc == 2) begin
                start     = 1'b1;
                base_addr = 16'h0100;
                length    = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [15:0] exp_wr   [4] = '{16'h5A5A, 16'h5A5B, 16'h5A58, 16'h5A59};
    logic [15:0] wrap_adr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int cyc;
        int w;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = 16'h0000;
        length    = 16'h0000;

        // Reset values, before any clock edge
        #2;
        check("rst_control", 32'(control), 32'h0);
        check("rst_data_oe", 32'(data_oe), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_done",    32'(done),    32'h0);
        check("rst_err",     32'(err_count), 32'h0);
        check("rst_fail",    32'(fail_addr), 32'h0);
        check("rst_addr",    32'(addr),    32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Ideal memory, base 0x10, 4 words: 2*4*(2+1) = 24 busy cycles
        run_test(16'h0010, 16'd4, 1'b0, cyc);
        check("t2_busy_cycles", 32'(cyc), 32'd24);
        check("t2_done", 32'(done), 32'h1);
        check("t2_busy", 32'(busy), 32'h0);
        check("t2_err",  32'(err_count), 32'h0);
        check("t2_fail", 32'(fail_addr), 32'h0);
        check("t2_naccess", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_wr%0d_ctrl", i), 32'(acc_log[i].ctrl), 32'h1);
            check($sformatf("t2_wr%0d_addr", i), 32'(acc_log[i].a), 32'h0010 + 32'(i));
            check($sformatf("t2_wr%0d_data", i), 32'(acc_log[i].d), 32'(exp_wr[i]));
            check($sformatf("t2_mem%0d", i), 32'(mem[16'h0010 + 16'(i)]), 32'(exp_wr[i]));
            check($sformatf("t2_rd%0d_ctrl", i), 32'(acc_log[4+i].ctrl), 32'h2);
            check($sformatf("t2_rd%0d_addr", i), 32'(acc_log[4+i].a), 32'h0010 + 32'(i));
        end

        // bit0 stuck-at-0: 0x12 holds 0x5A58 (bit0 already 0), only 0x13 fails
        fault_mode = 1;
        run_test(16'h0010, 16'd4, 1'b0, cyc);
        check("t3a_err",  32'(err_count), 32'd1);
        check("t3a_fail", 32'(fail_addr), 32'h0013);
        // bit0 inverted at 0x12 and 0x13: both fail, first at 0x12
        fault_mode = 2;
        run_test(16'h0010, 16'd4, 1'b0, cyc);
        check("t3b_err",  32'(err_count), 32'd2);
        check("t3b_fail", 32'(fail_addr), 32'h0012);
        check("t3b_done", 32'(done), 32'h1);
        fault_mode = 0;

        // Zero length from DONE: done next cycle, no access, results cleared
        run_test(16'h0040, 16'd0, 1'b0, cyc);
        check("t5_busy_cycles", 32'(cyc), 32'd0);
        check("t5_done", 32'(done), 32'h1);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_err",  32'(err_count), 32'h0);
        check("t5_fail", 32'(fail_addr), 32'h0);
        @(negedge clk);
        check("t5_control", 32'(control), 32'h0);
        check("t5_naccess", 32'(acc_log.size()), 32'd0);

        // Address wrap
        run_test(16'hFFFE, 16'd4, 1'b0, cyc);
        check("t4_busy_cycles", 32'(cyc), 32'd24);
        check("t4_err", 32'(err_count), 32'h0);
        check("t4_naccess", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_wr%0d_addr", i), 32'(acc_log[i].a),   32'(wrap_adr[i]));
            check($sformatf("t4_rd%0d_addr", i), 32'(acc_log[4+i].a), 32'(wrap_adr[i]));
        end

        // Reset during the second read cycle
        @(negedge clk);
        base_addr = 16'h0000;
        length    = 16'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (control != 2'b10 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("t6_reach_read", 32'(w < 200), 32'h1);
        @(posedge clk);
        #1;
        check("t6_rd_second_cycle", 32'(control), 32'h2);
        rst = 1'b0;
        #1;
        check("t6_rst_control", 32'(control), 32'h0);
        check("t6_rst_data_oe", 32'(data_oe), 32'h0);
        check("t6_rst_busy",    32'(busy),    32'h0);
        check("t6_rst_done",    32'(done),    32'h0);
        check("t6_rst_err",     32'(err_count), 32'h0);
        check("t6_rst_addr",    32'(addr),    32'h0);
        @(negedge clk);
        rst = 1'b1;
        // New single-word test with a stray start while busy: 2*1*3 = 6 cycles
        run_test(16'h0000, 16'd1, 1'b1, cyc);
        check("t6_busy_cycles", 32'(cyc), 32'd6);
        check("t6_done", 32'(done), 32'h1);
        check("t6_err",  32'(err_count), 32'h0);
        check("t6_naccess", 32'(acc_log.size()), 32'd2);
        check("t6_wr_addr", 32'(acc_log[0].a), 32'h0000);
        check("t6_wr_data", 32'(acc_log[0].d), 32'h5A5A);
        repeat (3) @(negedge clk);
        check("t6_still_done", 32'(done), 32'h1);
        check("bus_protocol", 32'(bad_bus), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
